pipeline_chroma_key_soft: RTL and testbench
===========================================

// Module: pipeline_chroma_key_soft
// PURPOSE
//  Next-generation chroma keyer for the pixel pipeline. Combines a background and a foreground RGB pixel
//  into a single output pixel. Key thresholds are runtime-programmable and applied on a frame boundary.
//  Pixels inside a soft band near the threshold are alpha-blended rather than hard-switched.
//  Registered, 3-stage, valid-qualified; also reports a per-frame count of fully-keyed pixels.
// PARAMETERS
//  RED_SIZE      5         red channel width
//  GREEN_SIZE    6         green channel width; also the common compare width (must be >= RED/BLUE)
//  BLUE_SIZE     5         blue channel width
//  PIXEL_SIZE    16        must equal RED_SIZE+GREEN_SIZE+BLUE_SIZE; layout {R,G,B}, R in MSBs
//  ALPHA_BITS    4         blend precision; alpha range 0..2**ALPHA_BITS
//  COUNT_W       20        width of the keyed-pixel counters
//  RED_PASS_RST  5'b00100  reset value of red_max
//  GREEN_PASS_RST 6'b101100 reset value of green_min
//  BLUE_PASS_RST 5'b01100  reset value of blue_max
// PORTS
//  clk            in   1           pixel clock
//  rst_n          in   1           asynchronous, active-low reset
//  enable         in   1           0: output bg unchanged; sampled with in_valid
//  in_valid       in   1           bg_pixel_in/fg_pixel_in valid this cycle
//  frame_start    in   1           qualified by in_valid; marks the first pixel of a frame
//  bg_pixel_in    in   PIXEL_SIZE  background pixel
//  fg_pixel_in    in   PIXEL_SIZE  foreground pixel
//  cfg_load       in   1           capture cfg_* into pending registers
//  cfg_red_max    in   RED_SIZE    key: red <= red_max
//  cfg_green_min  in   GREEN_SIZE  key: green >= green_min
//  cfg_blue_max   in   BLUE_SIZE   key: blue <= blue_max
//  cfg_soft_shift in   3           soft band = 2**soft_shift; values > ALPHA_BITS clamp to ALPHA_BITS
//  out_valid      out  1           pixel_out valid
//  pixel_out      out  PIXEL_SIZE  composited pixel
//  key_count_last out  COUNT_W     fully-keyed pixels in the previous complete frame
// BEHAVIOUR
//  Reset:
//   - out_valid=0, pixel_out=0, key_count_last=0, internal counter=0.
//   - Active and pending config = *_RST parameters, soft_shift=0. This is a hard key.
//  Config path:
//   - cfg_load writes the pending registers.
//   - The active config copies pending on (in_valid & frame_start). That pixel already uses the new config.
//   - cfg_load on the same cycle as a frame_start pixel bypasses: the cfg_* values go straight to active.
//  Latency: exactly 3 cycles, in_valid(t) -> out_valid(t+3). No backpressure. in_valid=0 creates bubbles
//  that propagate unchanged.
//  S1 (margin):
//   - Extend R and B to GREEN_SIZE by left shift; the thresholds are extended the same way.
//   - dr=rmax-r, dg=g-gmin, db=bmax-b, each signed GREEN_SIZE+1 bits.
//   - m=min(dr,dg,db).
//   - enable, bg and frame_start are registered alongside.
//  S2 (alpha), with band=2**s and A=2**ALPHA_BITS:
//   - m<0 gives alpha=0 (fg). m>=band-1 gives alpha=A (bg).
//   - Otherwise alpha=(m+1)<<(ALPHA_BITS-s).
//   - enable=0 forces alpha=A.
//  S3 (blend), per channel:
//   - out=(bg*alpha + fg*(A-alpha))>>ALPHA_BITS, truncated. Intermediate width is chan+ALPHA_BITS+1.
//   - alpha=A yields exactly bg; alpha=0 yields exactly fg.
//  Statistics:
//   - At S3, a valid pixel with alpha==A and enable=1 increments the counter. The counter saturates at all-ones.
//   - A valid S3 pixel carrying frame_start sets key_count_last <= counter and counter <= hit?1:0.
//  Boundaries:
//   - Reset mid-frame drops all in-flight pixels.
//   - With no frame_start ever seen, key_count_last stays 0.
//   - Two consecutive frame_starts: the counts are 0 or 1 accordingly.
// STRUCTURE
//  - Shared package pipeline_pkg: the pixel field offsets/widths and the ALPHA_BITS default.
//  - One sub-module, chroma_blend_channel #(W, ALPHA_BITS), registered. It is instantiated three times for R/G/B.
//  - Config shadowing, margin/alpha logic and the counter stay in this module.
// TESTING
//  1. Reset default, s=0. fg=16'h0580 (R0 G44 B0), bg=16'hFFFF.
//     -> out_valid 3 cycles later, pixel_out=16'hFFFF.
//     fg=16'hF800 -> pixel_out=16'hF800.
//  2. enable=0 with any fg, bg=16'h1234 -> pixel_out=16'h1234, counter unchanged.
//  3. Soft: s=1 loaded with frame_start.
//     fg G=44 at green_min=44 (m=0, other margins >=1) -> alpha=8.
//     bg=16'hFFFF, fg=16'h0580 -> each channel is the average, truncated.
//  4. cfg_load mid-frame (green_min=50): pixels before the next frame_start still key at 44.
//     The frame_start pixel uses 50.
//  5. Frame of 10 pixels with 6 keyed, then frame_start -> key_count_last=6 on that pixel's S3 cycle.
//  6. rst_n low with 2 pixels in flight -> out_valid=0, no stale output after release, counters 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pixel-pipeline definitions: default channel widths, blend precision and field helpers.
package pipeline_pkg;
  localparam int PKG_RED_SIZE   = 5;
  localparam int PKG_GREEN_SIZE = 6;
  localparam int PKG_BLUE_SIZE  = 5;
  localparam int PKG_ALPHA_BITS = 4;

  // channel index 0=R, 1=G, 2=B; pixel layout is {R,G,B} with R in the MSBs
  function automatic int chan_w(input int c, input int rs, input int gs, input int bs);
    return (c == 0) ? rs : (c == 1) ? gs : bs;
  endfunction

  function automatic int chan_lsb(input int c, input int gs, input int bs);
    return (c == 0) ? gs + bs : (c == 1) ? bs : 0;
  endfunction

  function automatic logic [2:0] clamp_shift(input logic [2:0] s, input int ab);
    return (int'(s) > ab) ? 3'(ab) : s;
  endfunction
endpackage

// File: rtl/chroma_blend_channel.sv
// One colour channel of the alpha blend: q = (bg*alpha + fg*(A-alpha)) >> ALPHA_BITS, registered.
module chroma_blend_channel #(
  parameter int W          = 5,
  parameter int ALPHA_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        bg,
  input  logic [W-1:0]        fg,
  input  logic [ALPHA_BITS:0] alpha,
  output logic [W-1:0]        q
);
  localparam int SW = W + ALPHA_BITS + 1;
  localparam logic [ALPHA_BITS:0] A_FULL = {1'b1, {ALPHA_BITS{1'b0}}};

  logic [ALPHA_BITS:0] inv;
  logic [SW-1:0]       sum;

  assign inv = A_FULL - alpha;
  assign sum = SW'(bg) * SW'(alpha) + SW'(fg) * SW'(inv);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= W'(sum >> ALPHA_BITS);
endmodule

// File: rtl/pipeline_chroma_key_soft.sv
// Soft chroma keyer: margin (S1), alpha (S2), per-channel blend (S3), with frame-shadowed config
// and a per-frame count of fully-keyed pixels.
module pipeline_chroma_key_soft
  import pipeline_pkg::*;
#(
  parameter int RED_SIZE   = PKG_RED_SIZE,
  parameter int GREEN_SIZE = PKG_GREEN_SIZE,
  parameter int BLUE_SIZE  = PKG_BLUE_SIZE,
  parameter int PIXEL_SIZE = 16,
  parameter int ALPHA_BITS = PKG_ALPHA_BITS,
  parameter int COUNT_W    = 20,
  parameter logic [RED_SIZE-1:0]   RED_PASS_RST   = 5'b00100,
  parameter logic [GREEN_SIZE-1:0] GREEN_PASS_RST = 6'b101100,
  parameter logic [BLUE_SIZE-1:0]  BLUE_PASS_RST  = 5'b01100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic                  frame_start,
  input  logic [PIXEL_SIZE-1:0] bg_pixel_in,
  input  logic [PIXEL_SIZE-1:0] fg_pixel_in,
  input  logic                  cfg_load,
  input  logic [RED_SIZE-1:0]   cfg_red_max,
  input  logic [GREEN_SIZE-1:0] cfg_green_min,
  input  logic [BLUE_SIZE-1:0]  cfg_blue_max,
  input  logic [2:0]            cfg_soft_shift,
  output logic                  out_valid,
  output logic [PIXEL_SIZE-1:0] pixel_out,
  output logic [COUNT_W-1:0]    key_count_last
);
  localparam int STAGES = 3;
  localparam int MW     = GREEN_SIZE + 1;
  localparam int AW     = ALPHA_BITS + 1;
  localparam int R_LSB  = chan_lsb(0, GREEN_SIZE, BLUE_SIZE);
  localparam int G_LSB  = chan_lsb(1, GREEN_SIZE, BLUE_SIZE);
  localparam int B_LSB  = chan_lsb(2, GREEN_SIZE, BLUE_SIZE);
  localparam logic [AW-1:0] A_FULL = {1'b1, {ALPHA_BITS{1'b0}}};

  logic [STAGES:1] vld_pipe;

  // ---------------- config shadowing ----------------
  logic [RED_SIZE-1:0]   pend_r, act_r, eff_r;
  logic [GREEN_SIZE-1:0] pend_g, act_g, eff_g;
  logic [BLUE_SIZE-1:0]  pend_b, act_b, eff_b;
  logic [2:0]            pend_s, act_s, eff_s;
  logic                  fs_in;

  assign fs_in = in_valid & frame_start;

  // a frame_start pixel already sees the new config; a same-cycle load bypasses pending
  always_comb begin
    eff_r = act_r; eff_g = act_g; eff_b = act_b; eff_s = act_s;
    if (fs_in) begin
      if (cfg_load) begin
        eff_r = cfg_red_max; eff_g = cfg_green_min; eff_b = cfg_blue_max;
        eff_s = clamp_shift(cfg_soft_shift, ALPHA_BITS);
      end else begin
        eff_r = pend_r; eff_g = pend_g; eff_b = pend_b; eff_s = pend_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_r <= RED_PASS_RST; pend_g <= GREEN_PASS_RST; pend_b <= BLUE_PASS_RST; pend_s <= '0;
      act_r  <= RED_PASS_RST; act_g  <= GREEN_PASS_RST; act_b  <= BLUE_PASS_RST; act_s  <= '0;
    end else begin
      if (cfg_load) begin
        pend_r <= cfg_red_max; pend_g <= cfg_green_min; pend_b <= cfg_blue_max;
        pend_s <= clamp_shift(cfg_soft_shift, ALPHA_BITS);
      end
      if (fs_in) begin
        act_r <= eff_r; act_g <= eff_g; act_b <= eff_b; act_s <= eff_s;
      end
    end

  // ---------------- S1: key margin ----------------
  logic [GREEN_SIZE-1:0] r_ext, b_ext, rmax_ext, bmax_ext;
  logic signed [MW-1:0]  dr, dg, db, m_c;

  always_comb begin
    r_ext    = GREEN_SIZE'(fg_pixel_in[R_LSB +: RED_SIZE]) << (GREEN_SIZE - RED_SIZE);
    b_ext    = GREEN_SIZE'(fg_pixel_in[B_LSB +: BLUE_SIZE]) << (GREEN_SIZE - BLUE_SIZE);
    rmax_ext = GREEN_SIZE'(eff_r) << (GREEN_SIZE - RED_SIZE);
    bmax_ext = GREEN_SIZE'(eff_b) << (GREEN_SIZE - BLUE_SIZE);
    dr  = $signed({1'b0, rmax_ext}) - $signed({1'b0, r_ext});
    dg  = $signed({1'b0, fg_pixel_in[G_LSB +: GREEN_SIZE]}) - $signed({1'b0, eff_g});
    db  = $signed({1'b0, bmax_ext}) - $signed({1'b0, b_ext});
    m_c = dr;
    if (dg < m_c) m_c = dg;
    if (db < m_c) m_c = db;
  end

  logic signed [MW-1:0]  s1_m;
  logic [2:0]            s1_shift;
  logic                  s1_en, s1_fs;
  logic [PIXEL_SIZE-1:0] s1_bg, s1_fg;

  // ---------------- S2: alpha ----------------
  logic [AW-1:0] alpha_c;
  int            band_m1;

  always_comb begin
    band_m1 = (1 << s1_shift) - 1;
    if (!s1_en)                      alpha_c = A_FULL;
    else if (s1_m < 0)               alpha_c = '0;
    else if (int'(s1_m) >= band_m1)  alpha_c = A_FULL;
    else alpha_c = AW'((int'(s1_m) + 1) << (ALPHA_BITS - int'(s1_shift)));
  end

  logic [AW-1:0]         s2_alpha;
  logic                  s2_en, s2_fs;
  logic [PIXEL_SIZE-1:0] s2_bg, s2_fg;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_m <= '0; s1_shift <= '0; s1_en <= 1'b0; s1_fs <= 1'b0; s1_bg <= '0; s1_fg <= '0;
      s2_alpha <= '0; s2_en <= 1'b0; s2_fs <= 1'b0; s2_bg <= '0; s2_fg <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_m <= m_c; s1_shift <= eff_s; s1_en <= enable; s1_fs <= frame_start;
      s1_bg <= bg_pixel_in; s1_fg <= fg_pixel_in;
      s2_alpha <= alpha_c; s2_en <= s1_en; s2_fs <= s1_fs; s2_bg <= s1_bg; s2_fg <= s1_fg;
    end

  assign out_valid = vld_pipe[STAGES];

  // ---------------- S3: blend ----------------
  for (genvar c = 0; c < 3; c++) begin : g_chan
    localparam int CW = chan_w(c, RED_SIZE, GREEN_SIZE, BLUE_SIZE);
    localparam int CL = chan_lsb(c, GREEN_SIZE, BLUE_SIZE);
    chroma_blend_channel #(.W(CW), .ALPHA_BITS(ALPHA_BITS)) u_blend (
      .clk   (clk),
      .rst_n (rst_n),
      .bg    (s2_bg[CL +: CW]),
      .fg    (s2_fg[CL +: CW]),
      .alpha (s2_alpha),
      .q     (pixel_out[CL +: CW])
    );
  end

  // ---------------- keyed-pixel statistics ----------------
  logic [COUNT_W-1:0] cnt;
  logic               hit;

  assign hit = vld_pipe[2] & s2_en & (s2_alpha == A_FULL);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0; key_count_last <= '0;
    end else if (vld_pipe[2] & s2_fs) begin
      key_count_last <= cnt;
      cnt            <= COUNT_W'(hit);
    end else if (hit && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipeline_chroma_key_soft.sv
// Scoreboard bench: stimulus pushes reference-model results, a negedge monitor pops and compares.
module tb_pipeline_chroma_key_soft;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        enable = 1'b0, in_valid = 1'b0, frame_start = 1'b0, cfg_load = 1'b0;
  logic [15:0] bg_pixel_in = '0, fg_pixel_in = '0;
  logic [4:0]  cfg_red_max = '0;
  logic [5:0]  cfg_green_min = '0;
  logic [4:0]  cfg_blue_max = '0;
  logic [2:0]  cfg_soft_shift = '0;
  logic        out_valid;
  logic [15:0] pixel_out;
  logic [19:0] key_count_last;

  pipeline_chroma_key_soft dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .frame_start(frame_start),
    .bg_pixel_in(bg_pixel_in), .fg_pixel_in(fg_pixel_in), .cfg_load(cfg_load),
    .cfg_red_max(cfg_red_max), .cfg_green_min(cfg_green_min), .cfg_blue_max(cfg_blue_max),
    .cfg_soft_shift(cfg_soft_shift), .out_valid(out_valid), .pixel_out(pixel_out),
    .key_count_last(key_count_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] px; logic [19:0] kcl; } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;

  // reference model state
  int p_r, p_g, p_b, p_s, a_r, a_g, a_b, a_s, m_cnt, m_kcl;
  int nxt_r, nxt_g, nxt_b, nxt_s;

  task automatic model_reset();
    p_r = 4; p_g = 44; p_b = 12; p_s = 0;
    a_r = 4; a_g = 44; a_b = 12; a_s = 0;
    m_cnt = 0; m_kcl = 0;
    q.delete();
  endtask

  // alpha on the 0..16 scale; 16 keeps the background, 0 keeps the foreground
  function automatic int key_alpha(input int fg, input int rm, input int gm, input int bm,
                                   input int s, input bit en);
    int r, g, b, m, band;
    r = (fg >> 11) & 31; g = (fg >> 5) & 63; b = fg & 31;
    m = (rm - r) * 2;
    if (g - gm < m) m = g - gm;
    if ((bm - b) * 2 < m) m = (bm - b) * 2;
    band = 1 << s;
    if (!en) return 16;
    if (m < 0) return 0;
    if (m >= band - 1) return 16;
    return (m + 1) * (16 / band);
  endfunction

  function automatic int blend(input int bg, input int fg, input int a);
    int res, bc, fc;
    int sh[3];
    int mk[3];
    sh = '{11, 5, 0}; mk = '{31, 63, 31};
    res = 0;
    for (int c = 0; c < 3; c++) begin
      bc = (bg >> sh[c]) & mk[c];
      fc = (fg >> sh[c]) & mk[c];
      res = res | (((bc * a + fc * (16 - a)) / 16) << sh[c]);
    end
    return res;
  endfunction

  // one input cycle; xp/xk >= 0 override the model with a hand-derived expectation
  task automatic cyc(input bit v, input bit fs, input bit en, input bit ld,
                     input int bg, input int fg, input int xp, input int xk);
    int er, eg, eb, es, a, px;
    bit hit;
    in_valid = v; frame_start = fs; enable = en; cfg_load = ld;
    bg_pixel_in = 16'(bg); fg_pixel_in = 16'(fg);
    cfg_red_max = 5'(nxt_r); cfg_green_min = 6'(nxt_g); cfg_blue_max = 5'(nxt_b);
    cfg_soft_shift = 3'(nxt_s);
    if (v && fs) begin
      if (ld) begin er = nxt_r; eg = nxt_g; eb = nxt_b; es = (nxt_s > 4) ? 4 : nxt_s; end
      else begin er = p_r; eg = p_g; eb = p_b; es = p_s; end
    end else begin
      er = a_r; eg = a_g; eb = a_b; es = a_s;
    end
    if (ld) begin p_r = nxt_r; p_g = nxt_g; p_b = nxt_b; p_s = (nxt_s > 4) ? 4 : nxt_s; end
    if (v && fs) begin a_r = er; a_g = eg; a_b = eb; a_s = es; end
    if (v) begin
      a = key_alpha(fg, er, eg, eb, es, en);
      hit = en && (a == 16);
      if (fs) begin m_kcl = m_cnt; m_cnt = hit ? 1 : 0; end
      else if (hit && m_cnt < (1 << 20) - 1) m_cnt++;
      px = blend(bg, fg, a);
      q.push_back('{px: 16'((xp >= 0) ? xp : px), kcl: 20'((xk >= 0) ? xk : m_kcl)});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, -1, -1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      n_tests++;
      if (out_valid !== 1'b0 || pixel_out !== 16'h0 || key_count_last !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_state: got vld=%b px=%h kcl=%0d, want 0/0000/0",
                 out_valid, pixel_out, key_count_last);
      end
    end else if (out_valid) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got px=%h kcl=%0d, want no output", pixel_out, key_count_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (pixel_out !== e.px || key_count_last !== e.kcl) begin
          n_fail++;
          $display("FAIL pixel: got px=%h kcl=%0d, want px=%h kcl=%0d",
                   pixel_out, key_count_last, e.px, e.kcl);
        end
      end
    end
  end

  initial begin
    int k, fg;
    nxt_r = 4; nxt_g = 44; nxt_b = 12; nxt_s = 0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // hard key at reset defaults; no frame_start yet so count stays 0
    cyc(1, 0, 1, 0, 16'hFFFF, 16'h0580, 16'hFFFF, 0);
    cyc(1, 0, 1, 0, 16'hFFFF, 16'hF800, 16'hF800, 0);
    // enable=0 passes background and does not count
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 16'h1234, int'($urandom_range(0, 65535)), 16'h1234, 0);
    // soft band s=1 loaded on frame_start (bypass); previous frame had one hit
    nxt_r = 4; nxt_g = 44; nxt_b = 12; nxt_s = 1;
    cyc(1, 1, 1, 1, 16'hFFFF, 16'h0580, 16'h7EAF, 1);
    cyc(1, 0, 1, 0, 16'hFFFF, 16'h0580, 16'h7EAF, -1);
    // mid-frame load waits for the next frame_start
    nxt_g = 50;
    cyc(0, 0, 0, 1, 0, 0, -1, -1);
    cyc(1, 0, 1, 0, 16'hFFFF, 16'h0580, 16'h7EAF, -1);
    cyc(1, 1, 1, 0, 16'hFFFF, 16'h0580, 16'h0580, 0);
    // 10-pixel frame with 6 keyed, then back-to-back frame_starts
    nxt_g = 44; nxt_s = 0;
    cyc(1, 1, 1, 1, 16'hFFFF, 16'h0580, 16'hFFFF, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 1, 0, int'($urandom_range(0, 65535)), (i < 5) ? 16'h0580 : 16'hF800, -1, -1);
      if (i == 3) idle(1);
    end
    cyc(1, 1, 1, 0, 16'h0F0F, 16'h0580, 16'h0F0F, 6);
    cyc(1, 1, 1, 0, 16'h0F0F, 16'hF800, 16'hF800, 1);
    cyc(1, 1, 1, 0, 16'h0F0F, 16'h0580, 16'h0F0F, 0);
    cyc(1, 1, 1, 0, 16'h0F0F, 16'hF800, 16'hF800, 1);

    // randomized traffic with random config loads and clamped soft shifts
    for (int i = 0; i < 400; i++) begin
      bit ld;
      ld = ($urandom_range(0, 9) == 0);
      if (ld) begin
        nxt_r = $urandom_range(0, 8); nxt_g = $urandom_range(30, 60);
        nxt_b = $urandom_range(4, 20); nxt_s = $urandom_range(0, 7);
      end
      if ($urandom_range(0, 1) == 1)
        fg = ($urandom_range(0, 5) << 11) | ($urandom_range(30, 63) << 5) | $urandom_range(0, 14);
      else
        fg = $urandom_range(0, 65535);
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, ld,
          $urandom_range(0, 65535), fg, -1, -1);
    end
    idle(5);

    // reset with two pixels in flight: they must vanish
    nxt_r = 4; nxt_g = 44; nxt_b = 12; nxt_s = 0;
    cyc(1, 1, 1, 0, 16'hAAAA, 16'h0580, -1, -1);
    cyc(1, 0, 1, 0, 16'h5555, 16'h0580, -1, -1);
    rst_n = 1'b0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(5);
    n_tests++;
    if (key_count_last !== 20'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got kcl=%0d vld=%b, want 0/0", key_count_last, out_valid);
    end
    cyc(1, 0, 1, 0, 16'hFFFF, 16'h0580, 16'hFFFF, 0);
    cyc(1, 1, 1, 0, 16'hFFFF, 16'hF800, 16'hF800, 1);

    k = 0;
    while (q.size() > 0 && k < 20) begin idle(1); k++; end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
